uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `uart_8n1` transmitter among `N_REQ` byte producers, such as character generators, status reporters and debug taps. It sits between the producers and the UART's `tx_data`/`tx_start`/`tx_busy` port. It launches one byte at a time, tracks the transmitter's busy window, enforces an inter-byte gap, and flags a transmitter that never goes busy.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of requester index, equal to ceil(log2(N_REQ)), minimum 1.
- `BUSY_TIMEOUT`, 16: cycles to wait for `tx_busy` to rise after `tx_start`.
- `GAP_CYCLES`, 0: idle hclk cycles inserted after `tx_busy` falls, before the next launch.
- `hclk` in 1: system clock, the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester "byte pending"; held high until acked.
- `req_data` in 8*N_REQ: byte of requester i on bits [8i+7:8i]; stable while req[i] is high.
- `ack` out N_REQ: one-cycle one-hot pulse; the requester's byte was taken.
- `tx_data` out 8: to UART; registered copy of the winner's byte.
- `tx_start` out 1: to UART; one-cycle launch pulse.
- `tx_busy` in 1: from UART; high while a frame is being shifted.
- `active_id` out ID_W: index of the last granted requester.
- `sched_busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: one-cycle pulse; `tx_busy` failed to rise within BUSY_TIMEOUT.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_RISE, WAIT_FALL, GAP.
- IDLE, when any req is high:
  - pick the winner by round-robin, starting at index `last+1` mod N_REQ;
  - register `tx_data`=req_data[winner] and `active_id`=winner;
  - go to LAUNCH.
- LAUNCH:
  - `tx_start`=1 and `ack[winner]`=1 for exactly this cycle;
  - set `last`=winner;
  - clear the timeout counter;
  - go to WAIT_RISE.
- WAIT_RISE:
  - if `tx_busy`=1, go to WAIT_FALL;
  - otherwise increment the counter; when it reaches BUSY_TIMEOUT, pulse `err_timeout` and go to IDLE. The byte is dropped and already acked.
- WAIT_FALL: when `tx_busy`=0, go to GAP if GAP_CYCLES>0, else to IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- `tx_data` holds its value from LAUNCH until the next IDLE-to-LAUNCH transition. It never changes while `tx_busy` is high.
- A req that drops before being granted is simply not served. A req that stays high after its ack is treated as a new byte.
- Requests arriving in any non-IDLE state wait; they are arbitrated on the next IDLE cycle.
- Single requester: served back-to-back, with priority returning to it each time.
- Out-of-range winner indices cannot occur; the priority mask covers only N_REQ bits.

## Timing
- Reset values:
  - state=IDLE, `last`=N_REQ-1, so index 0 has first priority;
  - `tx_data`=0, `tx_start`=0, `ack`=0, `active_id`=0, `sched_busy`=0, `err_timeout`=0, counters=0.
- Reset asserted mid-frame returns to IDLE immediately. `tx_start` and `ack` are never left high.
- Latency: req high in IDLE at edge k gives `tx_start`/`ack` high during cycle k+1.
- All outputs are registered; there is no combinational path from `req` to `ack` or `tx_start`.
- Minimum launch-to-launch spacing: 2 + (busy rise delay) + (frame length) + 1 + GAP_CYCLES cycles.
- Timeout counter width is ceil(log2(BUSY_TIMEOUT+1)). The gap counter is sized likewise. Counters saturate and never wrap.

## Structure
- The state encoding (5 states, localparam) and the default timeout/gap values go in the shared `uart_pkg` include. `uart_8n1` and the top level reuse the same constants.
- One sub-module, `rr_pick`:
  - purely combinational;
  - inputs `req` and `last`;
  - outputs a one-hot `grant` plus its binary index;
  - implemented with a double-width masked priority encoder.
- The top level instantiates `uart_tx_arbiter` between the producers and `uart_8n1`, tying `rst` through an inverter where needed.

## Test plan
- Reset, then hold req=4'b0001 with data 8'h61 and a UART model that is busy 10 cycles after start. Expect `tx_start` one cycle after req, `tx_data`=8'h61, `ack`=0001, and a relaunch only after busy falls.
- All four req high with data 41,42,43,44. Expect grant order 0,1,2,3,0 and `ack` one-hot every frame.
- From `last`=1, req=4'b1001. Expect requester 3 to be served before 0.
- UART model never raises `tx_busy`, BUSY_TIMEOUT=16. Expect `err_timeout` pulse 17 cycles after `tx_start`, then return to IDLE and serve the next req.
- GAP_CYCLES=5. Expect exactly 5 IDLE-gap cycles between busy fall and the next arbitration.
- Assert `rst` in WAIT_FALL. Expect all outputs 0 immediately, and the first grant after release going to index 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared scheduler state encoding, default timing constants and counter sizing.
// Items: state_t (IDLE, LAUNCH, WAIT_RISE, WAIT_FALL, GAP), DEF_BUSY_TIMEOUT, DEF_GAP_CYCLES, cnt_w().
package uart_tx_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_RISE, WAIT_FALL, GAP} state_t;
    localparam int N_STATES = 5;
    localparam int DEF_BUSY_TIMEOUT = 16;
    localparam int DEF_GAP_CYCLES = 0;
    // Width that can hold 0..v; a zero limit still needs one bit.
    function automatic int cnt_w(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts just above the last winner.
// Ports: req (pending requests), last (previous winner index),
//        grant (one-hot winner, zero when no request), idx (binary winner index).
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);
    logic [2*N-1:0] dbl;
    logic hit;
    // Lower copy keeps only bits above last, upper copy is unmasked, so the
    // first set bit wraps around from last+1 back through last.
    always_comb begin
        dbl = {req, req};
        for (int i = 0; i < N; i++) dbl[i] = req[i] && (i > int'(last));
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!hit && dbl[i]) begin
                hit = 1'b1;
                idx = W'(i % N);
            end
        end
        grant = hit ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one 8N1 transmitter among N_REQ byte producers.
// Ports: hclk (clock), rst (async, active-low), req/req_data (producer bytes), ack (one-hot take pulse),
//        tx_data/tx_start/tx_busy (transmitter handshake), active_id (last granted index),
//        sched_busy (not IDLE), err_timeout (tx_busy never rose after a launch).
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W = 2,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                 hclk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      active_id,
    output logic                 sched_busy,
    output logic                 err_timeout
);
    localparam int TW = cnt_w(BUSY_TIMEOUT);
    localparam int GW = cnt_w(GAP_CYCLES);

    state_t state, state_nxt;
    logic [ID_W-1:0] last, last_nxt, win, active_id_nxt;
    logic [N_REQ-1:0] grant, ack_nxt;
    logic [7:0] tx_data_nxt;
    logic tx_start_nxt, err_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt, tcnt_inc;
    logic [GW-1:0] gcnt, gcnt_nxt, gcnt_inc;

    rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
        .req  (req),
        .last (last),
        .grant(grant),
        .idx  (win)
    );

    assign tcnt_inc = (tcnt == '1) ? tcnt : tcnt + 1'b1;
    assign gcnt_inc = (gcnt == '1) ? gcnt : gcnt + 1'b1;

    // Pulses are decided one cycle ahead and registered, so tx_start/ack are
    // flop outputs that are high exactly while the FSM sits in LAUNCH.
    always_comb begin
        state_nxt = state;
        last_nxt = last;
        active_id_nxt = active_id;
        tx_data_nxt = tx_data;
        ack_nxt = '0;
        tx_start_nxt = 1'b0;
        err_nxt = 1'b0;
        tcnt_nxt = tcnt;
        gcnt_nxt = gcnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = LAUNCH;
                    tx_data_nxt = req_data[8*win +: 8];
                    active_id_nxt = win;
                    ack_nxt = grant;
                    tx_start_nxt = 1'b1;
                end
            end
            LAUNCH: begin
                last_nxt = active_id;
                tcnt_nxt = '0;
                state_nxt = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (tx_busy) state_nxt = WAIT_FALL;
                else begin
                    tcnt_nxt = tcnt_inc;
                    if (tcnt_inc == TW'(BUSY_TIMEOUT)) begin
                        err_nxt = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_FALL: begin
                if (!tx_busy) begin
                    gcnt_nxt = '0;
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                gcnt_nxt = gcnt_inc;
                if (gcnt_inc == GW'(GAP_CYCLES)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last <= ID_W'(N_REQ - 1);
            active_id <= '0;
            tx_data <= '0;
            ack <= '0;
            tx_start <= 1'b0;
            err_timeout <= 1'b0;
            sched_busy <= 1'b0;
            tcnt <= '0;
            gcnt <= '0;
        end else begin
            state <= state_nxt;
            last <= last_nxt;
            active_id <= active_id_nxt;
            tx_data <= tx_data_nxt;
            ack <= ack_nxt;
            tx_start <= tx_start_nxt;
            err_timeout <= err_nxt;
            sched_busy <= (state_nxt != IDLE);
            tcnt <= tcnt_nxt;
            gcnt <= gcnt_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter with simple transmitter busy models.
module tb_uart_tx_arbiter;
    logic hclk, rst;
    logic [3:0] req, req_g, ack, ack_g;
    logic [31:0] req_data;
    logic [7:0] tx_data, tx_data_g;
    logic tx_start, tx_start_g, tx_busy, tx_busy_g;
    logic [1:0] active_id, active_id_g;
    logic sched_busy, sched_busy_g, err_timeout, err_g;
    int total = 0;
    int bad = 0;
    int n;
    int unsigned bcnt = 0;
    int unsigned bcnt_g = 0;
    bit mute = 0;

    uart_tx_arbiter #(.N_REQ(4), .ID_W(2), .BUSY_TIMEOUT(16), .GAP_CYCLES(0)) dut (
        .hclk(hclk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .active_id(active_id), .sched_busy(sched_busy), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(.N_REQ(4), .ID_W(2), .BUSY_TIMEOUT(16), .GAP_CYCLES(5)) dut_g (
        .hclk(hclk), .rst(rst), .req(req_g), .req_data(req_data), .ack(ack_g),
        .tx_data(tx_data_g), .tx_start(tx_start_g), .tx_busy(tx_busy_g),
        .active_id(active_id_g), .sched_busy(sched_busy_g), .err_timeout(err_g)
    );

    initial hclk = 0;
    always #5 hclk = ~hclk;

    // Transmitter models: busy for 10 (main) or 3 (gap instance) cycles after a sampled start.
    always @(posedge hclk) begin
        if (tx_start && !mute) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        if (tx_start_g) bcnt_g <= 3;
        else if (bcnt_g != 0) bcnt_g <= bcnt_g - 1;
    end
    assign tx_busy = (bcnt != 0);
    assign tx_busy_g = (bcnt_g != 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " tx_start"}, 32'(tx_start), 0);
        chk({tag, " ack"}, 32'(ack), 0);
        chk({tag, " tx_data"}, 32'(tx_data), 0);
        chk({tag, " active_id"}, 32'(active_id), 0);
        chk({tag, " sched_busy"}, 32'(sched_busy), 0);
        chk({tag, " err"}, 32'(err_timeout), 0);
    endtask

    task automatic wait_start(input bit g, input int lim, output int cnt);
        cnt = 0;
        do begin
            @(negedge hclk);
            cnt++;
        end while (!(g ? tx_start_g : tx_start) && cnt < lim);
    endtask

    task automatic wait_idle(input int lim, output int cnt);
        cnt = 0;
        do begin
            @(negedge hclk);
            cnt++;
        end while (sched_busy && cnt < lim);
    endtask

    initial begin
        rst = 0;
        req = 0;
        req_g = 0;
        req_data = {8'h44, 8'h43, 8'h42, 8'h61};
        repeat (3) @(negedge hclk);
        chk_zero("reset");
        rst = 1;
        // single requester, back-to-back
        @(negedge hclk);
        req = 4'b0001;
        @(negedge hclk);
        chk("t1 tx_start", 32'(tx_start), 1);
        chk("t1 ack", 32'(ack), 1);
        chk("t1 tx_data", 32'(tx_data), 32'h61);
        chk("t1 active_id", 32'(active_id), 0);
        chk("t1 sched_busy", 32'(sched_busy), 1);
        wait_start(0, 40, n);
        chk("t1 spacing", n, 13);
        chk("t1 ack2", 32'(ack), 1);
        chk("t1 tx_data2", 32'(tx_data), 32'h61);
        // reset, then all four requesting
        rst = 0;
        req = 0;
        req_data[7:0] = 8'h41;
        @(negedge hclk);
        chk_zero("reset2");
        rst = 1;
        req = 4'hf;
        for (int k = 0; k < 5; k++) begin
            wait_start(0, 40, n);
            chk("t2 tx_start", 32'(tx_start), 1);
            chk("t2 active_id", 32'(active_id), k % 4);
            chk("t2 ack", 32'(ack), 32'(1) << (k % 4));
            chk("t2 tx_data", 32'(tx_data), 32'h41 + (k % 4));
        end
        // last=1 then req 1001: 3 before 0
        req = 4'b0010;
        wait_start(0, 40, n);
        chk("t3 id1", 32'(active_id), 1);
        req = 4'b1001;
        wait_start(0, 40, n);
        chk("t3 id3", 32'(active_id), 3);
        wait_start(0, 40, n);
        chk("t3 id0", 32'(active_id), 0);
        req = 0;
        // transmitter never goes busy
        wait_idle(40, n);
        mute = 1;
        req = 4'b0100;
        wait_start(0, 40, n);
        chk("t4 id2", 32'(active_id), 2);
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!err_timeout && n < 40);
        chk("t4 err delay", n, 17);
        chk("t4 idle", 32'(sched_busy), 0);
        mute = 0;
        @(negedge hclk);
        chk("t4 err pulse", 32'(err_timeout), 0);
        chk("t4 next start", 32'(tx_start), 1);
        chk("t4 next id", 32'(active_id), 0);
        req = 0;
        // gap instance: 3-cycle frames plus 5 gap cycles
        req_g = 4'b0001;
        wait_start(1, 40, n);
        chk("t5 ack", 32'(ack_g), 1);
        chk("t5 tx_data", 32'(tx_data_g), 32'h41);
        wait_start(1, 40, n);
        chk("t5 gap spacing", n, 11);
        chk("t5 id", 32'(active_id_g), 0);
        req_g = 0;
        chk("t5 err", 32'(err_g), 0);
        // reset in WAIT_FALL
        wait_idle(40, n);
        req = 4'b0010;
        wait_start(0, 40, n);
        chk("t6 id1", 32'(active_id), 1);
        req = 4'b0011;
        repeat (2) @(negedge hclk);
        chk("t6 busy", 32'(sched_busy), 1);
        rst = 0;
        #1;
        chk_zero("mid reset");
        repeat (2) @(negedge hclk);
        rst = 1;
        wait_start(0, 40, n);
        chk("t6 first id", 32'(active_id), 0);
        chk("t6 first ack", 32'(ack), 1);
        chk("t6 g busy", 32'(sched_busy_g), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
